// File: rtl/lvdc_pkg.sv
// Shared constants, state encoding and helpers for the lvdc boot loader.
package lvdc_pkg;

  localparam int unsigned LVDC_ADDR_W = 15;
  localparam int unsigned LVDC_WORD_W = 26;
  localparam int unsigned HDR_BYTES   = 4;
  localparam int unsigned WORD_BYTES  = 4;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_VERIFY,
    ST_RELEASE,
    ST_DONE,
    ST_ERR
  } load_state_t;

  // Mask of the bits of a 32-bit little-endian field that lie above a w-bit word.
  function automatic logic [31:0] upper_mask(input int unsigned w);
    logic [31:0] m;
    m = '1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/lvdc_loader_asm.sv
// Little-endian byte-to-word assembler shared by the header and data fields.
// Header and data words are both four bytes, so one counter serves both.
module lvdc_loader_asm
  import lvdc_pkg::*;
#(
  parameter int unsigned WORD_W = LVDC_WORD_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word_c,
  output logic        last_c,
  output logic        bad_c
);

  localparam int unsigned IDX_W = $clog2(WORD_BYTES);
  localparam logic [31:0] UPPER_MASK = upper_mask(WORD_W);

  logic [IDX_W-1:0] idx;
  logic [23:0]      acc;

  // Low three bytes are held; the top byte is taken straight from the input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
      acc <= '0;
    end else if (take) begin
      idx <= idx + IDX_W'(1);
      case (idx)
        IDX_W'(0): acc[7:0]   <= data;
        IDX_W'(1): acc[15:8]  <= data;
        IDX_W'(2): acc[23:16] <= data;
        default: ;
      endcase
    end
  end

  assign word_c = {data, acc};
  assign last_c = take && (idx == IDX_W'(WORD_BYTES - 1));
  assign bad_c  = |(word_c & UPPER_MASK);

endmodule

// File: rtl/lvdc_loader.sv
// Boot-time program loader: framed byte stream -> main memory writes, holds core in reset.
// Optional read-back verify pass enabled by defining LVDC_LOADER_VERIFY_EN.
module lvdc_loader
  import lvdc_pkg::*;
#(
  parameter int unsigned ADDR_W         = LVDC_ADDR_W,
  parameter int unsigned WORD_W         = LVDC_WORD_W,
  parameter int unsigned CPU_RST_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
`ifdef LVDC_LOADER_VERIFY_EN
  input  logic [WORD_W-1:0] mem_rval,
`endif
  output logic              in_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wval,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = $clog2(CPU_RST_CYCLES + 1);
  localparam int unsigned LEN_W = ADDR_W + 1;

  load_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic [7:0]        csum;
  logic [CNT_W-1:0]  rel_cnt;

  logic              take;
  logic              asm_take;
  logic [31:0]       asm_word;
  logic              asm_last;
  logic              asm_bad;
  logic [7:0]        csum_next;
  logic [15:0]       hdr_len;
  logic [15:0]       hdr_addr;
  logic              len_too_big;

`ifdef LVDC_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  n_len;
  logic [WORD_W-1:0] wxor;
  logic [WORD_W-1:0] vxor;
  logic [WORD_W-1:0] vxor_next;
  assign vxor_next = vxor ^ mem_rval;
`endif

  assign take        = in_valid && in_ready;
  assign asm_take    = take && ((state == ST_HDR) || (state == ST_DATA));
  assign csum_next   = csum + in_data;
  assign hdr_addr    = asm_word[15:0];
  assign hdr_len     = asm_word[31:16];
  assign len_too_big = 32'(hdr_len) > (32'd1 << ADDR_W);

  lvdc_loader_asm #(
    .WORD_W (WORD_W)
  ) u_asm (
    .clk    (clk),
    .rst    (rst),
    .take   (asm_take),
    .data   (in_data),
    .word_c (asm_word),
    .last_c (asm_last),
    .bad_c  (asm_bad)
  );

  // Loader FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_HDR;
      in_ready <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_wval <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      addr     <= '0;
      rem      <= '0;
      csum     <= '0;
      rel_cnt  <= '0;
`ifdef LVDC_LOADER_VERIFY_EN
      start_addr <= '0;
      n_len      <= '0;
      wxor       <= '0;
      vxor       <= '0;
`endif
    end else begin
      mem_wen <= 1'b0;
      if (take) csum <= csum_next;
      case (state)
        ST_HDR: begin
          in_ready <= 1'b1;
          if (asm_last) begin
            addr <= ADDR_W'(hdr_addr);
            rem  <= LEN_W'(hdr_len);
`ifdef LVDC_LOADER_VERIFY_EN
            start_addr <= ADDR_W'(hdr_addr);
            n_len      <= LEN_W'(hdr_len);
`endif
            if (len_too_big) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (hdr_len == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (asm_last) begin
            if (asm_bad) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              mem_wen  <= 1'b1;
              mem_addr <= addr;
              mem_wval <= asm_word[WORD_W-1:0];
              addr     <= addr + ADDR_W'(1);
              rem      <= rem - LEN_W'(1);
`ifdef LVDC_LOADER_VERIFY_EN
              wxor <= wxor ^ asm_word[WORD_W-1:0];
`endif
              if (rem == LEN_W'(1)) state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (take) begin
            in_ready <= 1'b0;
            rel_cnt  <= '0;
            if (csum_next == 8'd0) begin
`ifdef LVDC_LOADER_VERIFY_EN
              if (n_len == '0) begin
                state <= ST_RELEASE;
              end else begin
                state    <= ST_VERIFY;
                mem_addr <= start_addr;
                rem      <= n_len;
                vxor     <= '0;
              end
`else
              state <= ST_RELEASE;
`endif
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`ifdef LVDC_LOADER_VERIFY_EN
        // One word read back per cycle; the final word is folded in combinationally.
        ST_VERIFY: begin
          vxor <= vxor_next;
          rem  <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            if (vxor_next == wxor) begin
              state <= ST_RELEASE;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
`endif
        ST_RELEASE: begin
          if (rel_cnt == CNT_W'(CPU_RST_CYCLES)) begin
            cpu_rst <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            rel_cnt <= rel_cnt + CNT_W'(1);
          end
        end
        ST_DONE: ;
        ST_ERR: begin
          in_ready <= 1'b0;
          error    <= 1'b1;
          cpu_rst  <= 1'b1;
        end
        default: begin
          state    <= ST_ERR;
          in_ready <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvdc_loader.sv
// Randomized frame-level bench for lvdc_loader against a behavioural frame model.
module tb_lvdc_loader;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned WORD_W = 26;
  localparam int unsigned CPU_RST_CYCLES = 3;
  localparam int MEM_SIZE = 32768;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wval;
  logic              cpu_rst;
  logic              done;
  logic              error;

`ifdef LVDC_LOADER_VERIFY_EN
  logic [WORD_W-1:0] mem [0:MEM_SIZE-1];
  logic [WORD_W-1:0] mem_rval;
  assign mem_rval = mem[mem_addr];
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  lvdc_loader #(
    .ADDR_W         (ADDR_W),
    .WORD_W         (WORD_W),
    .CPU_RST_CYCLES (CPU_RST_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef LVDC_LOADER_VERIFY_EN
    .mem_rval (mem_rval),
`endif
    .in_ready (in_ready),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wval (mem_wval),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fall_cyc = -1;
  int          last_acc = 0;
  logic [7:0]  frame_q[$];
  logic [31:0] words_q[$];
  int          wa_q[$];
  logic [31:0] wd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe memory writes and the cpu_rst release mid-cycle.
  always @(negedge clk) begin
    if (rst && mem_wen) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(32'(mem_wval));
`ifdef LVDC_LOADER_VERIFY_EN
      mem[mem_addr] <= mem_wval;
`endif
    end
    if (rst && !cpu_rst && fall_cyc < 0) fall_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wval", 32'(mem_wval), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wa_q.delete();
    wd_q.delete();
    fall_cyc = -1;
  endtask

  // Offer one byte with a random lead-in gap; give up after a bounded wait.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit r;
    ok = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      if (r) ok = 1'b1;
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    if (ok) last_acc = cyc;
  endtask

  task automatic build_frame(input logic [15:0] start, input logic [15:0] n, input logic [7:0] adj);
    logic [7:0] s;
    frame_q.delete();
    frame_q.push_back(start[7:0]);
    frame_q.push_back(start[15:8]);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    if (int'(n) <= MEM_SIZE) begin
      foreach (words_q[i]) begin
        for (int k = 0; k < 4; k++) frame_q.push_back(8'(words_q[i] >> (8 * k)));
      end
    end else begin
      for (int k = 0; k < 3; k++) frame_q.push_back(8'($urandom));
    end
    s = 8'd0;
    foreach (frame_q[i]) s = s + frame_q[i];
    frame_q.push_back(8'(8'd0 - s) + adj);
  endtask

  // Send a whole frame and compare the result with the model of the frame rules.
  task automatic run_frame(input logic [15:0] start, input logic [15:0] n, input logic [7:0] adj,
                           input bit corrupt);
    int          exp_a[$];
    logic [31:0] exp_d[$];
    int          exp_acc, err_idx, nw, acc_n, lat;
    bit          exp_err, ok;
    logic [7:0]  s;
    build_frame(start, n, adj);
    exp_acc = frame_q.size();
    exp_err = 1'b0;
    err_idx = -1;
    if (int'(n) > MEM_SIZE) begin
      exp_err = 1'b1;
      exp_acc = 4;
      err_idx = 3;
    end else begin
      foreach (words_q[i]) begin
        if (!exp_err) begin
          if ((words_q[i] >> WORD_W) != 0) begin
            exp_err = 1'b1;
            exp_acc = 4 + 4 * (i + 1);
            err_idx = exp_acc - 1;
          end else begin
            exp_a.push_back((int'(start) + i) % MEM_SIZE);
            exp_d.push_back(words_q[i]);
          end
        end
      end
      if (!exp_err) begin
        s = 8'd0;
        foreach (frame_q[i]) s = s + frame_q[i];
        if (s != 8'd0) begin
          exp_err = 1'b1;
          err_idx = frame_q.size() - 1;
        end
      end
    end
    nw = exp_a.size();
    acc_n = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], ok);
      if (ok) begin
        acc_n++;
        if (i == err_idx) check("err_now", 32'(error), 32'd1);
        if (i >= 4 && i < 4 + 4 * nw && ((i - 4) % 4) == 3) check("wen_now", 32'(mem_wen), 32'd1);
      end
    end
`ifdef LVDC_LOADER_VERIFY_EN
    if (corrupt && !exp_err && nw >= 2) begin
      mem[(int'(start) + 1) % MEM_SIZE] = mem[(int'(start) + 1) % MEM_SIZE] ^ 26'h1;
      exp_err = 1'b1;
    end
`endif
    repeat (CPU_RST_CYCLES + nw + 8) @(posedge clk);
    #1;
    check("accepted", 32'(acc_n), 32'(exp_acc));
    check("n_writes", 32'(wa_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      check("wr_addr", 32'(wa_q[i]), 32'(exp_a[i]));
      check("wr_data", wd_q[i], exp_d[i]);
    end
    check("error", 32'(error), 32'(exp_err));
    check("done", 32'(done), 32'(!exp_err));
    check("cpu_rst", 32'(cpu_rst), 32'(exp_err));
    check("in_ready", 32'(in_ready), 32'd0);
    if (exp_err) begin
      check("no_release", 32'(fall_cyc < 0), 32'd1);
    end else begin
      lat = fall_cyc - last_acc;
      check("rel_latency", 32'(lat), 32'(CPU_RST_CYCLES + 1 + (VERIFY ? nw : 0)));
    end
  endtask

  task automatic expect_ignored();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), ok);
      check("ignored", 32'(ok), 32'd0);
    end
  endtask

  initial begin
    bit          ok;
    logic [15:0] n;
    logic [31:0] w;
`ifdef LVDC_LOADER_VERIFY_EN
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = '0;
`endif
    do_reset();

    words_q = '{32'h0123_4567, 32'h03FF_FFFF};
    run_frame(16'h0010, 16'd2, 8'd0, 1'b0);
    expect_ignored();

    do_reset();
    run_frame(16'h0010, 16'd2, 8'd1, 1'b0);
    expect_ignored();

    do_reset();
    words_q = '{32'h02AA_5555, 32'h0155_AAAA};
    run_frame(16'h7FFF, 16'd2, 8'd0, 1'b0);

    do_reset();
    words_q.delete();
    run_frame(16'h8123, 16'd0, 8'd0, 1'b0);

    do_reset();
    run_frame(16'h0000, 16'h8001, 8'd0, 1'b0);

    do_reset();
    words_q = '{32'h0000_0001, 32'h0400_0000, 32'h0000_0002};
    run_frame(16'h0100, 16'd3, 8'd0, 1'b0);

    // Abandon a frame mid-DATA, then load a fresh one.
    do_reset();
    words_q = '{32'h0000_1111, 32'h0000_2222};
    build_frame(16'h0200, 16'd2, 8'd0);
    for (int i = 0; i < 6; i++) send_byte(frame_q[i], ok);
    do_reset();
    words_q = '{32'h0333_3333, 32'h0000_0042};
    run_frame(16'h0300, 16'd2, 8'd0, 1'b0);

`ifdef LVDC_LOADER_VERIFY_EN
    do_reset();
    words_q = '{32'h0123_4567, 32'h03FF_FFFF};
    run_frame(16'h0010, 16'd2, 8'd0, 1'b1);
`endif

    for (int t = 0; t < 40; t++) begin
      do_reset();
      words_q.delete();
      if ($urandom_range(0, 9) == 0) begin
        n = 16'(32'h8001 + $urandom_range(0, 32'h7FFE));
      end else begin
        n = 16'($urandom_range(0, 5));
        for (int i = 0; i < int'(n); i++) begin
          w = $urandom & 32'h03FF_FFFF;
          if ($urandom_range(0, 11) == 0) w = w | (32'd1 << $urandom_range(26, 31));
          words_q.push_back(w);
        end
      end
      run_frame(16'($urandom), n, ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
